// File: rtl/fpu_issue_stage_pkg.sv
// Shared definitions for the FPU issue/capture stage: opcodes, the quiet-NaN
// constant returned for unsupported operations, and the issue FSM states.
package fpu_issue_stage_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    localparam logic [31:0] QNAN_SINGLE = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } issue_state_t;

    // The FPU implements only the four opcodes with bit 2 clear.
    function automatic logic op_supported(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/fpu_issue_stage.sv
// Issue/capture stage in front of the combinational FPU: registers a request,
// holds it stable for SETTLE_CYCLES, captures the result and returns it tagged.
module fpu_issue_stage
    import fpu_issue_stage_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 4,
    parameter int          TAG_W         = 4,
    parameter logic [31:0] QNAN          = QNAN_SINGLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_op_a,
    input  logic [31:0]      req_op_b,
    input  logic [2:0]       req_operation,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      fpu_op_a,
    output logic [31:0]      fpu_op_b,
    output logic [2:0]       fpu_operation,
    input  logic [31:0]      fpu_result,
    input  logic             fpu_overflow,
    input  logic             fpu_underflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_overflow,
    output logic             rsp_underflow,
    output logic             rsp_invalid,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [2:0]       flags_sticky,
    input  logic             flags_clear,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // The requester holds its data while req_ready is low; the response stays
    // stable in HOLD until rsp_ready, and a new request may fire on that same edge.
    issue_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic             fire;
    logic             rsp_hs;
    logic [2:0]       hs_flags;

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        if (!rst) begin
            req_ready = (state == IDLE) || ((state == HOLD) && rsp_ready);
            rsp_valid = (state == HOLD);
        end
        fire     = req_valid && req_ready;
        rsp_hs   = rsp_valid && rsp_ready;
        hs_flags = {rsp_invalid, rsp_underflow, rsp_overflow};
        busy     = (state != IDLE);
        dbg_state = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            fpu_op_a      <= '0;
            fpu_op_b      <= '0;
            fpu_operation <= '0;
            rsp_result    <= '0;
            rsp_overflow  <= 1'b0;
            rsp_underflow <= 1'b0;
            rsp_invalid   <= 1'b0;
            rsp_tag       <= '0;
            flags_sticky  <= '0;
        end else begin
            // A clear coinciding with a handshake keeps only that handshake's flags.
            if (rsp_hs)
                flags_sticky <= (flags_clear ? 3'b000 : flags_sticky) | hs_flags;
            else if (flags_clear)
                flags_sticky <= 3'b000;

            case (state)
                IDLE, HOLD: begin
                    if (fire) begin
                        rsp_tag <= req_tag;
                        if (op_supported(req_operation)) begin
                            fpu_op_a      <= req_op_a;
                            fpu_op_b      <= req_op_b;
                            fpu_operation <= req_operation;
                            cnt           <= CNT_W'(SETTLE_CYCLES - 1);
                            state         <= EVAL;
                        end else begin
                            rsp_result    <= QNAN;
                            rsp_invalid   <= 1'b1;
                            rsp_overflow  <= 1'b0;
                            rsp_underflow <= 1'b0;
                            state         <= HOLD;
                        end
                    end else if (rsp_hs) begin
                        state <= IDLE;
                    end
                end
                EVAL: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        rsp_result    <= fpu_result;
                        rsp_overflow  <= fpu_overflow;
                        rsp_underflow <= fpu_underflow;
                        rsp_invalid   <= 1'b0;
                        state         <= HOLD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_stage.sv
// Bench for fpu_issue_stage: a stand-in FPU with fixed answers for the directed
// vectors, directed scenarios, then randomized transactions against a reference model.
module tb_fpu_issue_stage;
    import fpu_issue_stage_pkg::*;

    localparam int SETTLE = 4;
    localparam int TW     = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_op_a;
    logic [31:0]   req_op_b;
    logic [2:0]    req_operation;
    logic [TW-1:0] req_tag;
    logic [31:0]   fpu_op_a;
    logic [31:0]   fpu_op_b;
    logic [2:0]    fpu_operation;
    logic [31:0]   fpu_result;
    logic          fpu_overflow;
    logic          fpu_underflow;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_result;
    logic          rsp_overflow;
    logic          rsp_underflow;
    logic          rsp_invalid;
    logic [TW-1:0] rsp_tag;
    logic [2:0]    flags_sticky;
    logic          flags_clear;
    logic          busy;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [2:0]    m_sticky;
    logic [31:0]   m_fa, m_fb;
    logic [2:0]    m_fop;
    logic [31:0]   e_res;
    logic          e_ov, e_un, e_inv;
    logic [TW-1:0] e_tag;

    fpu_issue_stage #(.SETTLE_CYCLES(SETTLE), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op_a(req_op_a), .req_op_b(req_op_b),
        .req_operation(req_operation), .req_tag(req_tag),
        .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b), .fpu_operation(fpu_operation),
        .fpu_result(fpu_result), .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
        .rsp_underflow(rsp_underflow), .rsp_invalid(rsp_invalid),
        .rsp_tag(rsp_tag), .flags_sticky(flags_sticky), .flags_clear(flags_clear),
        .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Stand-in FPU: exact IEEE answers for the directed vectors, a cheap mix otherwise.
    function automatic logic [33:0] fpu_stub(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op);
        logic [31:0] r;
        if (op == OP_ADD && a == 32'h3F80_0000 && b == 32'h4000_0000) return {2'b00, 32'h4040_0000};
        if (op == OP_SUB && a == 32'h4040_0000 && b == 32'h3F80_0000) return {2'b00, 32'h4000_0000};
        if (op == OP_MUL && a == 32'h7F00_0000 && b == 32'h7F00_0000) return {2'b10, 32'h7F80_0000};
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_MUL:  r = a ^ {b[15:0], b[31:16]};
            default: r = {a[15:0], b[15:0]};
        endcase
        return {r[31] & r[0], r[30] & ~r[1], r};
    endfunction

    assign {fpu_overflow, fpu_underflow, fpu_result} = fpu_stub(fpu_op_a, fpu_op_b, fpu_operation);

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present a request at a negedge; it fires on the next posedge.
    task automatic do_req(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [TW-1:0] tag);
        int guard = 0;
        req_valid = 1'b1; req_op_a = a; req_op_b = b; req_operation = op; req_tag = tag;
        while (!req_ready && guard < 20) begin step(); guard++; end
        check_eq("req_ready_before_fire", req_ready, 1);
        step();
        req_valid = 1'b0;
        if (op < 3'd4) begin m_fa = a; m_fb = b; m_fop = op; end
        check_eq("fpu_op_a", fpu_op_a, m_fa);
        check_eq("fpu_op_b", fpu_op_b, m_fb);
        check_eq("fpu_operation", fpu_operation, m_fop);
    endtask

    // Called at the negedge just after the accepting edge; latency counts posedges after it.
    task automatic wait_rsp(input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op, input logic [TW-1:0] tag);
        int lat = 0;
        logic [33:0] s;
        if (op >= 3'd4) begin
            e_res = QNAN_SINGLE; e_ov = 1'b0; e_un = 1'b0; e_inv = 1'b1;
        end else begin
            s = fpu_stub(a, b, op);
            e_res = s[31:0]; e_ov = s[33]; e_un = s[32]; e_inv = 1'b0;
        end
        e_tag = tag;
        while (!rsp_valid && lat < 20) begin step(); lat++; end
        check_eq("rsp_latency", lat, (op >= 3'd4) ? 0 : SETTLE);
        check_rsp_data("rsp");
    endtask

    task automatic check_rsp_data(input string tag);
        check_eq({tag, "_result"}, rsp_result, e_res);
        check_eq({tag, "_flags"}, {rsp_invalid, rsp_underflow, rsp_overflow}, {e_inv, e_un, e_ov});
        check_eq({tag, "_tag"}, rsp_tag, e_tag);
    endtask

    task automatic take_rsp(input logic clear);
        rsp_ready = 1'b1; flags_clear = clear;
        step();
        rsp_ready = 1'b0; flags_clear = 1'b0;
        m_sticky = (clear ? 3'b000 : m_sticky) | {e_inv, e_un, e_ov};
        check_eq("sticky_after_hs", flags_sticky, m_sticky);
        check_eq("valid_after_hs", rsp_valid, 0);
        check_eq("busy_after_hs", busy, 0);
        check_rsp_data("retained");
    endtask

    task automatic hold_stable(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check_eq("hold_valid", rsp_valid, 1);
            check_eq("hold_req_ready", req_ready, 0);
            check_rsp_data("hold");
            check_eq("hold_fpu_a", fpu_op_a, m_fa);
        end
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                           input logic [TW-1:0] tag, input int hold, input logic clear);
        do_req(a, b, op, tag);
        wait_rsp(a, b, op, tag);
        hold_stable(hold);
        take_rsp(clear);
    endtask

    initial begin
        int seen;
        rst = 1'b1; req_valid = 1'b0; req_op_a = '0; req_op_b = '0; req_operation = '0;
        req_tag = '0; rsp_ready = 1'b0; flags_clear = 1'b0;
        m_sticky = '0; m_fa = '0; m_fb = '0; m_fop = '0;
        e_res = '0; e_ov = 0; e_un = 0; e_inv = 0; e_tag = '0;
        step(); step();
        check_eq("reset_req_ready", req_ready, 0);
        rst = 1'b0;
        #1;
        check_eq("reset_req_ready_released", req_ready, 1);
        check_eq("reset_outputs", {rsp_valid, busy, flags_sticky, rsp_result, rsp_tag}, 0);
        check_eq("reset_fpu", {fpu_op_a, fpu_op_b, fpu_operation}, 0);
        step();

        // Directed vectors
        run_txn(32'h3F80_0000, 32'h4000_0000, OP_ADD, 4'd3, 0, 1'b0);
        check_eq("t1_result_const", rsp_result, 32'h4040_0000);
        run_txn(32'h7F00_0000, 32'h7F00_0000, OP_MUL, 4'd1, 1, 1'b0);
        check_eq("t2_sticky_const", flags_sticky, 3'b001);
        run_txn(32'h1234_5678, 32'h9ABC_DEF0, 3'b100, 4'd9, 0, 1'b0);
        check_eq("t3_sticky_const", flags_sticky, 3'b101);
        check_eq("t3_fpu_unchanged", fpu_op_a, 32'h7F00_0000);

        // Response held off with a queued request, then back-to-back acceptance
        do_req(32'h0000_0010, 32'h0000_0020, OP_ADD, 4'd5);
        wait_rsp(32'h0000_0010, 32'h0000_0020, OP_ADD, 4'd5);
        req_valid = 1'b1; req_op_a = 32'h4040_0000; req_op_b = 32'h3F80_0000;
        req_operation = OP_SUB; req_tag = 4'd6;
        hold_stable(10);
        rsp_ready = 1'b1;
        #1 check_eq("b2b_req_ready", req_ready, 1);
        step();
        rsp_ready = 1'b0; req_valid = 1'b0;
        m_sticky = m_sticky | {e_inv, e_un, e_ov};
        m_fa = 32'h4040_0000; m_fb = 32'h3F80_0000; m_fop = OP_SUB;
        check_eq("b2b_valid_dropped", rsp_valid, 0);
        check_eq("b2b_busy", busy, 1);
        check_eq("b2b_fpu_a", fpu_op_a, m_fa);
        check_eq("b2b_sticky", flags_sticky, m_sticky);
        wait_rsp(32'h4040_0000, 32'h3F80_0000, OP_SUB, 4'd6);
        check_eq("b2b_result_const", rsp_result, 32'h4000_0000);
        take_rsp(1'b0);

        // Reset in the middle of EVAL drops the request
        do_req(32'h3F80_0000, 32'h4000_0000, OP_ADD, 4'd7);
        step();
        #1 rst = 1'b1;
        #1;
        check_eq("abort_outputs", {rsp_valid, busy, flags_sticky, rsp_result, req_ready}, 0);
        check_eq("abort_fpu", {fpu_op_a, fpu_op_b, fpu_operation}, 0);
        step(); step();
        rst = 1'b0;
        m_sticky = '0; m_fa = '0; m_fb = '0; m_fop = '0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin step(); seen += rsp_valid; end
        check_eq("abort_no_rsp", seen, 0);
        run_txn(32'h3F80_0000, 32'h4000_0000, OP_ADD, 4'd8, 0, 1'b0);

        // Clear coinciding with an overflowing handshake
        run_txn(32'h0, 32'h0, 3'b111, 4'd2, 0, 1'b0);
        check_eq("t6_sticky_before", flags_sticky, 3'b100);
        run_txn(32'h7F00_0000, 32'h7F00_0000, OP_MUL, 4'd4, 0, 1'b1);
        check_eq("t6_sticky_after", flags_sticky, 3'b001);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            run_txn($urandom, $urandom, op, TW'($urandom_range(0, 15)),
                    $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 3) == 0) begin
                flags_clear = 1'b1;
                step();
                flags_clear = 1'b0;
                m_sticky = '0;
                check_eq("rand_clear", flags_sticky, m_sticky);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
